// File: rtl/riscv_mem_arbiter.sv
`timescale 1ns/1ps
// Shares one single-port memory between the core fetch port (I) and load/store port (D).
// Data has priority; a streak limit bounds how long a pending fetch can be starved.
module riscv_mem_arbiter #(
    parameter int unsigned MEM_LAT      = 1,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_done,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int unsigned SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] StreakMax = SW'(MAX_D_STREAK);
    localparam logic [1:0] LatInit = 2'(MEM_LAT - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;

    state_e        state_q, state_d;
    logic          owner_q, owner_d;  // 1 = D port owns the access
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [1:0]    lat_q, lat_d;
    logic [31:0]   i_rdata_q, i_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          pick_d;
    logic          capture;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        streak_d  = streak_q;
        lat_d     = lat_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        pick_d    = 1'b0;
        capture   = 1'b0;

        case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    // Fetch wins a contested slot only once D has used up its streak.
                    pick_d  = d_req &&
                              !(i_req && (MAX_D_STREAK != 0) && (streak_q == StreakMax));
                    state_d = StAccess;
                    if (pick_d) begin
                        owner_d = 1'b1;
                        we_d    = d_we;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        if (i_req && (streak_q != StreakMax)) begin
                            streak_d = streak_q + 1'b1;
                        end
                    end else begin
                        owner_d  = 1'b0;
                        we_d     = 1'b0;
                        addr_d   = i_addr;
                        wdata_d  = '0;
                        streak_d = '0;
                    end
                end
            end
            StAccess: begin
                lat_d = LatInit;
                if (MEM_LAT == 1) begin
                    state_d = StDone;
                    capture = 1'b1;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                lat_d = lat_q - 2'd1;
                if (lat_q == 2'd1) begin
                    state_d = StDone;
                    capture = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (capture && !we_q) begin
            if (owner_q) begin
                d_rdata_d = mem_rdata;
            end else begin
                i_rdata_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            streak_q  <= '0;
            lat_q     <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            streak_q  <= streak_d;
            lat_q     <= lat_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign mem_en    = (state_q == StAccess);
    assign mem_we    = (state_q == StAccess) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_done    = (state_q == StDone) && !owner_q;
    assign d_done    = (state_q == StDone) && owner_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
`timescale 1ns/1ps
// Bench for riscv_mem_arbiter: instance A (MEM_LAT=1, MAX_D_STREAK=4) and instance B
// (MEM_LAT=3, MAX_D_STREAK=0) share one directed stimulus and a transaction-level model.
module tb_riscv_mem_arbiter;

    localparam int unsigned LAT0  = 1;
    localparam int unsigned LAT1  = 3;
    localparam int unsigned MAXS0 = 4;
    localparam int unsigned MAXS1 = 0;

    localparam logic [32:0] IF1 = {1'b0, 32'h0062b233};  // fetch from 0x10
    localparam logic [32:0] IF2 = {1'b0, 32'h0083b233};  // fetch from 0x4
    localparam logic [32:0] DL  = {1'b1, 32'h00000008};  // D done with d_rdata 0x8

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;

    logic        i_done_w [2];
    logic        d_done_w [2];
    logic        mem_en_w [2];
    logic        mem_we_w [2];
    logic        busy_w   [2];
    logic [31:0] i_rdata_w   [2];
    logic [31:0] d_rdata_w   [2];
    logic [31:0] mem_addr_w  [2];
    logic [31:0] mem_wdata_w [2];
    logic [31:0] mem_rdata_w [2];

    int total = 0;
    int bad   = 0;

    riscv_mem_arbiter #(.MEM_LAT(LAT0), .MAX_D_STREAK(MAXS0)) u_a (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done_w[0]), .i_rdata(i_rdata_w[0]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done_w[0]), .d_rdata(d_rdata_w[0]),
        .mem_en(mem_en_w[0]), .mem_we(mem_we_w[0]), .mem_addr(mem_addr_w[0]),
        .mem_wdata(mem_wdata_w[0]), .mem_rdata(mem_rdata_w[0]), .busy(busy_w[0])
    );

    riscv_mem_arbiter #(.MEM_LAT(LAT1), .MAX_D_STREAK(MAXS1)) u_b (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done_w[1]), .i_rdata(i_rdata_w[1]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done_w[1]), .d_rdata(d_rdata_w[1]),
        .mem_en(mem_en_w[1]), .mem_we(mem_we_w[1]), .mem_addr(mem_addr_w[1]),
        .mem_wdata(mem_wdata_w[1]), .mem_rdata(mem_rdata_w[1]), .busy(busy_w[1])
    );

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        case (a)
            32'h10:  mem_val = 32'h0062b233;
            32'h4:   mem_val = 32'h0083b233;
            32'h100: mem_val = 32'h00000008;
            default: mem_val = a ^ 32'h5a5a0000;
        endcase
    endfunction

    // Memory drives real data only in the cycle MEM_LAT-1 after mem_en, garbage otherwise.
    for (genvar g = 0; g < 2; g++) begin : g_mem
        localparam int unsigned L  = (g == 0) ? LAT0 : LAT1;
        localparam int unsigned HI = (L >= 2) ? L - 2 : 0;
        logic [3:0] hist = '0;
        always @(posedge clk) hist <= {hist[2:0], mem_en_w[g]};
        assign mem_rdata_w[g] = ((L == 1) ? mem_en_w[g] : hist[HI]) ?
                                mem_val(mem_addr_w[g]) : 32'hdeadbeef;
    end

    function automatic int unsigned lat_of(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    function automatic int unsigned maxs_of(input int k);
        return (k == 0) ? MAXS0 : MAXS1;
    endfunction

    function automatic string nm(input int k, input string s);
        return $sformatf("%s.%s", (k == 0) ? "A" : "B", s);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got 0x%h want 0x%h", name, $time, act, exp);
        end
    endtask

    // Transaction-level model: one access runs for cycles 1..lat+1 after the grant cycle.
    bit          m_act    [2];
    int unsigned m_c      [2];
    bit          m_own    [2];
    bit          m_we     [2];
    logic [31:0] m_addr   [2];
    logic [31:0] m_wd     [2];
    logic [31:0] m_ird    [2];
    logic [31:0] m_drd    [2];
    int unsigned m_streak [2];

    task automatic model_step(input int k);
        bit pick_d;
        if (rst) begin
            m_act[k] = 0; m_c[k] = 0; m_own[k] = 0; m_we[k] = 0;
            m_addr[k] = '0; m_wd[k] = '0; m_ird[k] = '0; m_drd[k] = '0; m_streak[k] = 0;
        end else if (m_act[k]) begin
            if (m_c[k] == lat_of(k) && !m_we[k]) begin
                if (m_own[k]) m_drd[k] = mem_val(m_addr[k]);
                else          m_ird[k] = mem_val(m_addr[k]);
            end
            if (m_c[k] == lat_of(k) + 1) m_act[k] = 0;
            else                         m_c[k]++;
        end else if (i_req || d_req) begin
            pick_d = d_req && !(i_req && maxs_of(k) != 0 && m_streak[k] == maxs_of(k));
            if (pick_d) begin
                m_own[k] = 1; m_we[k] = d_we; m_addr[k] = d_addr; m_wd[k] = d_wdata;
                if (i_req && m_streak[k] < maxs_of(k)) m_streak[k]++;
            end else begin
                m_own[k] = 0; m_we[k] = 0; m_addr[k] = i_addr; m_wd[k] = '0;
                m_streak[k] = 0;
            end
            m_act[k] = 1;
            m_c[k]   = 1;
        end
    endtask

    task automatic compare(input int k);
        bit en_e, done_e;
        en_e   = m_act[k] && (m_c[k] == 1);
        done_e = m_act[k] && (m_c[k] == lat_of(k) + 1);
        chk(nm(k, "busy"),      32'(busy_w[k]),     32'(m_act[k]));
        chk(nm(k, "mem_en"),    32'(mem_en_w[k]),   32'(en_e));
        chk(nm(k, "mem_we"),    32'(mem_we_w[k]),   32'(en_e && m_we[k]));
        chk(nm(k, "mem_addr"),  mem_addr_w[k],      m_addr[k]);
        chk(nm(k, "mem_wdata"), mem_wdata_w[k],     m_wd[k]);
        chk(nm(k, "i_done"),    32'(i_done_w[k]),   32'(done_e && !m_own[k]));
        chk(nm(k, "d_done"),    32'(d_done_w[k]),   32'(done_e && m_own[k]));
        chk(nm(k, "i_rdata"),   i_rdata_w[k],       m_ird[k]);
        chk(nm(k, "d_rdata"),   d_rdata_w[k],       m_drd[k]);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) model_step(k);
            @(negedge clk);
            for (int k = 0; k < 2; k++) compare(k);
        end
    end

    // Log of every done pulse as {owner, owner's rdata}.
    logic [32:0] log_a[$];
    logic [32:0] log_b[$];
    always @(negedge clk) begin
        if (i_done_w[0]) log_a.push_back({1'b0, i_rdata_w[0]});
        if (d_done_w[0]) log_a.push_back({1'b1, d_rdata_w[0]});
        if (i_done_w[1]) log_b.push_back({1'b0, i_rdata_w[1]});
        if (d_done_w[1]) log_b.push_back({1'b1, d_rdata_w[1]});
    end

    logic [32:0] exp_a[$] = '{IF1, DL, IF2, DL,
                              DL, DL, DL, DL, IF2, DL, DL, DL,
                              IF1, IF1, IF1, IF1, IF1,
                              IF1, IF1};
    logic [32:0] exp_b[$] = '{IF1, DL, IF2, DL,
                              DL, DL, DL, DL, DL,
                              IF1, IF1, IF1,
                              IF1};

    initial begin
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk(nm(k, "reset busy"), 32'(busy_w[k]), 32'h0);
            chk(nm(k, "reset mem_addr"), mem_addr_w[k], 32'h0);
            chk(nm(k, "reset i_rdata"), i_rdata_w[k], 32'h0);
        end

        // Single fetch from 0x10.
        @(posedge clk); #1 i_req = 1'b1; i_addr = 32'h10;
        @(posedge clk); #1 i_req = 1'b0;
        @(negedge clk);
        chk("A.lit mem_en c1", 32'(mem_en_w[0]), 32'h1);
        chk("A.lit mem_addr c1", mem_addr_w[0], 32'h10);
        chk("B.lit mem_en c1", 32'(mem_en_w[1]), 32'h1);
        @(negedge clk);
        chk("A.lit i_done c2", 32'(i_done_w[0]), 32'h1);
        chk("A.lit i_rdata c2", i_rdata_w[0], 32'h0062b233);
        chk("A.lit busy c2", 32'(busy_w[0]), 32'h1);
        repeat (6) @(posedge clk);
        #1;

        // Simultaneous load from 0x100 and fetch from 0x4: D first.
        i_req = 1'b1; i_addr = 32'h4; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        @(posedge clk); #1 d_req = 1'b0;
        repeat (5) @(posedge clk);
        #1 i_req = 1'b0;
        repeat (12) @(posedge clk);
        #1;

        // Store to 0x200.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hfffffff8;
        @(posedge clk); #1 d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        chk("A.lit store mem_we", 32'(mem_we_w[0]), 32'h1);
        chk("A.lit store mem_addr", mem_addr_w[0], 32'h200);
        chk("A.lit store mem_wdata", mem_wdata_w[0], 32'hfffffff8);
        @(negedge clk);
        chk("A.lit store d_done", 32'(d_done_w[0]), 32'h1);
        chk("A.lit store d_rdata kept", d_rdata_w[0], 32'h8);
        chk("A.lit store i_rdata kept", i_rdata_w[0], 32'h0083b233);
        repeat (6) @(posedge clk);
        #1;

        // Both requests held: streak fairness on A, strict D priority on B.
        i_req = 1'b1; i_addr = 32'h4; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        repeat (24) @(posedge clk);
        #1 i_req = 1'b0; d_req = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // Back-to-back fetches: B issues mem_en every 5 cycles.
        i_req = 1'b1; i_addr = 32'h10;
        @(negedge clk);
        @(negedge clk);
        chk("B.lit mem_en c1", 32'(mem_en_w[1]), 32'h1);
        repeat (3) @(negedge clk);
        chk("B.lit i_done c4", 32'(i_done_w[1]), 32'h1);
        @(negedge clk);
        chk("B.lit mem_en c5", 32'(mem_en_w[1]), 32'h0);
        @(negedge clk);
        chk("B.lit mem_en c6", 32'(mem_en_w[1]), 32'h1);
        repeat (5) @(negedge clk);
        chk("B.lit mem_en c11", 32'(mem_en_w[1]), 32'h1);
        repeat (4) @(posedge clk);
        #1 i_req = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // Reset while B waits on memory: access abandoned, no done.
        i_req = 1'b1; i_addr = 32'h10;
        @(posedge clk); #1 i_req = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("B.lit rst busy", 32'(busy_w[1]), 32'h0);
        chk("B.lit rst mem_en", 32'(mem_en_w[1]), 32'h0);
        chk("B.lit rst i_rdata", i_rdata_w[1], 32'h0);
        chk("B.lit rst d_rdata", d_rdata_w[1], 32'h0);
        chk("A.lit rst i_rdata", i_rdata_w[0], 32'h0);
        @(posedge clk); #1 i_req = 1'b1; i_addr = 32'h10;
        @(posedge clk); #1 i_req = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);

        chk("A.done count", 32'(log_a.size()), 32'(exp_a.size()));
        for (int n = 0; n < exp_a.size() && n < log_a.size(); n++)
            chk($sformatf("A.done log %0d", n), {log_a[n][32], 31'h0} | log_a[n][31:0],
                {exp_a[n][32], 31'h0} | exp_a[n][31:0]);
        chk("B.done count", 32'(log_b.size()), 32'(exp_b.size()));
        for (int n = 0; n < exp_b.size() && n < log_b.size(); n++)
            chk($sformatf("B.done log %0d", n), {log_b[n][32], 31'h0} | log_b[n][31:0],
                {exp_b[n][32], 31'h0} | exp_b[n][31:0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
